// File: rtl/regfile_read_arbiter_pkg.sv
// Shared constants for the register-file read arbiter: mux geometry and the
// fixed requester slot assignments.
package regfile_read_arbiter_pkg;

    localparam int REG_SEL_WIDTH  = 4;
    localparam int REG_DATA_WIDTH = 32;

    localparam int REQ_DEBUG  = 0;
    localparam int REQ_ISSUE1 = 1;
    localparam int REQ_TRACE  = 2;
    localparam int REQ_SPARE  = 3;

endpackage

// File: rtl/regfile_read_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: finds the first asserted request starting
// at the pointer and wrapping, and reports it one-hot, encoded and as a valid flag.
module rr_priority_picker
    import regfile_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]  o_onehot,
    output logic [ID_WIDTH-1:0] o_index,
    output logic                o_any
);

    logic [ID_WIDTH-1:0] w_cand;

    // The first hit in ptr-relative order wins; later hits are ignored.
    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        o_any    = 1'b0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = ID_WIDTH'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_onehot[w_cand] = 1'b1;
                o_index          = w_cand;
                o_any            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 16:1 register read mux among NUM_REQ requesters.
// Optional RDARB_CONFLICT_STATS_EN adds a saturating conflict_count output.
module regfile_read_arbiter
    import regfile_read_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [4*NUM_REQ-1:0]       addr,
    output logic [REG_SEL_WIDTH-1:0]   mux_select,
    input  logic [DATA_WIDTH-1:0]      mux_out,
    output logic [NUM_REQ-1:0]         grant,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       rvalid,
    output logic [ID_WIDTH-1:0]        rid
`ifdef RDARB_CONFLICT_STATS_EN
    ,
    output logic [15:0]                conflict_count
`endif
);

    logic [ID_WIDTH-1:0]      r_ptr;
    logic [NUM_REQ-1:0]       r_grant;
    logic [REG_SEL_WIDTH-1:0] r_mux_select;
    logic [ID_WIDTH-1:0]      r_id;
    logic                     r_v1;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_rvalid;
    logic [ID_WIDTH-1:0]      r_rid;

    logic [NUM_REQ-1:0]       w_req_masked;
    logic [NUM_REQ-1:0]       w_win_onehot;
    logic [ID_WIDTH-1:0]      w_win_idx;
    logic                     w_win_any;
    logic [REG_SEL_WIDTH-1:0] w_win_addr;
    logic [ID_WIDTH-1:0]      w_ptr_next;

    // Whoever holds grant this cycle sits out the next edge, so a requester
    // dropping req after seeing grant is never granted twice.
    assign w_req_masked = req & ~r_grant;

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .i_req    (w_req_masked),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_onehot),
        .o_index  (w_win_idx),
        .o_any    (w_win_any)
    );

    always_comb begin
        w_win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == ID_WIDTH'(i)) begin
                w_win_addr = addr[i*4 +: 4];
            end
        end
    end

    assign w_ptr_next = (w_win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;

    // Stage 1 registers the grant and mux select; stage 2 captures mux data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            r_grant      <= '0;
            r_mux_select <= '0;
            r_id         <= '0;
            r_v1         <= 1'b0;
            r_rdata      <= '0;
            r_rvalid     <= 1'b0;
            r_rid        <= '0;
        end else begin
            r_grant  <= w_win_onehot;
            r_v1     <= w_win_any;
            r_rvalid <= r_v1;
            if (w_win_any) begin
                r_mux_select <= w_win_addr;
                r_id         <= w_win_idx;
                r_ptr        <= w_ptr_next;
            end
            if (r_v1) begin
                r_rdata <= mux_out;
                r_rid   <= r_id;
            end
        end
    end

    assign grant      = r_grant;
    assign mux_select = r_mux_select;
    assign rdata      = r_rdata;
    assign rvalid     = r_rvalid;
    assign rid        = r_rid;

`ifdef RDARB_CONFLICT_STATS_EN
    logic [15:0] r_conflict_count;
    logic        w_multi;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_multi = |(w_req_masked & (w_req_masked - 1'b1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict_count <= '0;
        end else if (w_multi && (r_conflict_count != 16'hFFFF)) begin
            r_conflict_count <= r_conflict_count + 16'd1;
        end
    end

    assign conflict_count = r_conflict_count;
`endif

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for regfile_read_arbiter: directed phases then random traffic
// checked against a round-robin reference model (also covers RDARB_CONFLICT_STATS_EN).
module tb_regfile_read_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ID_WIDTH   = 2;
    localparam int DATA_WIDTH = 32;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } sbEntry_t;

    logic                    clk;
    logic                    reset;
    logic [NUM_REQ-1:0]      req;
    logic [4*NUM_REQ-1:0]    addr;
    logic [3:0]              mux_select;
    logic [DATA_WIDTH-1:0]   mux_out;
    logic [NUM_REQ-1:0]      grant;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic [ID_WIDTH-1:0]     rid;
`ifdef RDARB_CONFLICT_STATS_EN
    logic [15:0]             conflict_count;
    int                      expConflict = 0;
`endif

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          modelPtr   = 0;
    int          maskIdx    = -1;
    logic [3:0]  expGrant   = '0;
    logic [3:0]  expSel     = '0;
    logic [31:0] expRdata   = '0;
    int          expRid     = 0;
    sbEntry_t    sb[$];

    regfile_read_arbiter #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REQ    (NUM_REQ),
        .ID_WIDTH   (ID_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .addr       (addr),
        .mux_select (mux_select),
        .mux_out    (mux_out),
        .grant      (grant),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rid        (rid)
`ifdef RDARB_CONFLICT_STATS_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    // Shared register file stand-in: each register reads back as A000_0000 + index.
    assign mux_out = 32'hA000_0000 + {28'd0, mux_select};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // Drives one cycle of inputs and advances the reference model across the coming edge.
    task automatic applyStimulus(input logic rst, input logic [NUM_REQ-1:0] r, input logic [4*NUM_REQ-1:0] a);
        int win;
        int nUnmasked;
        int idx;
        sbEntry_t e;
        @(negedge clk);
        reset = rst;
        req   = r;
        addr  = a;
        if (rst) begin
            modelPtr = 0;
            maskIdx  = -1;
            expGrant = '0;
            expSel   = '0;
            expRdata = '0;
            expRid   = 0;
            sb.delete();
`ifdef RDARB_CONFLICT_STATS_EN
            expConflict = 0;
`endif
        end else begin
            win = -1;
            nUnmasked = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (modelPtr + k) % NUM_REQ;
                if (r[idx] && idx != maskIdx) begin
                    nUnmasked++;
                    if (win < 0) win = idx;
                end
            end
`ifdef RDARB_CONFLICT_STATS_EN
            if (nUnmasked >= 2 && expConflict < 65535) expConflict++;
`endif
            if (win >= 0) begin
                expGrant = 4'(1 << win);
                expSel   = a[win*4 +: 4];
                e.id     = win;
                e.data   = 32'hA000_0000 + {28'd0, expSel};
                e.due    = cyc + 2;
                sb.push_back(e);
                modelPtr = (win + 1) % NUM_REQ;
                maskIdx  = win;
            end else begin
                expGrant = '0;
                maskIdx  = -1;
            end
        end
    endtask

    // Monitor: per-cycle register checks, plus scoreboard pops on rvalid.
    initial begin
        sbEntry_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rvalid) begin
                if (sb.size() == 0) begin
                    checkOutput("rvalid_spurious", 32'(rvalid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rid", 32'(rid), 32'(e.id));
                    checkOutput("rdata", rdata, e.data);
                    checkOutput("rvalid_latency", 32'(cyc), 32'(e.due));
                    expRdata = e.data;
                    expRid   = e.id;
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checkOutput("rvalid_missing", 32'(rvalid), 32'd1);
            end
            checkOutput("grant", 32'(grant), 32'(expGrant));
            checkOutput("mux_select", 32'(mux_select), 32'(expSel));
            checkOutput("rdata_hold", rdata, expRdata);
            checkOutput("rid_hold", 32'(rid), 32'(expRid));
`ifdef RDARB_CONFLICT_STATS_EN
            checkOutput("conflict_count", 32'(conflict_count), 32'(expConflict));
`endif
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, compared %0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        addr  = '0;

        // Reset held with every requester asking.
        applyStimulus(1'b1, 4'b1111, 16'h4321);
        applyStimulus(1'b1, 4'b1111, 16'h4321);

        // All requesters held: expect 0,1,2,3,0,... with unique addresses.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'b1111, 16'hD5A3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0000, 16'hD5A3);

        // Single read of register 9 from requester 1.
        applyStimulus(1'b0, 4'b0010, 16'h0090);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0000, 16'h0090);

        // Lone requester 2 held: granted every other cycle.
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'b0100, 16'h0E00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0000, 16'h0E00);

        // Reset while a grant is in flight; pointer must come back to 0.
        applyStimulus(1'b0, 4'b1110, 16'h7654);
        applyStimulus(1'b0, 4'b1110, 16'h7654);
        applyStimulus(1'b1, 4'b1110, 16'h7654);
        applyStimulus(1'b0, 4'b0000, 16'h7654);
        applyStimulus(1'b0, 4'b1111, 16'h7654);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0000, 16'h7654);

        // Conflict phase then single-requester phase.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'b0101, 16'h3C1B);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b0001, 16'h3C1B);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)), 16'($urandom));
        end

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0000, 16'h0000);
        @(negedge clk);
        checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
